// File: rtl/vram_scanout_if.sv
// Render-side bus of the scanout stage: VRAM read port, palette write port,
// border select and the outgoing VGA video signals.
interface vram_scanout_if;
  logic [14:0] render_addr;
  logic [7:0]  render_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic [3:0]  border_idx;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;

  modport master (
    output render_addr, rgb, hsync, vsync, de, frame_start,
    input  render_data, pal_we, pal_addr, pal_data, border_idx
  );

  modport slave (
    input  render_addr, rgb, hsync, vsync, de, frame_start,
    output render_data, pal_we, pal_addr, pal_data, border_idx
  );
endinterface

// File: rtl/vram_scanout.sv
// 640x480@60 VGA scanout: fetches a 256x192 4 bpp framebuffer from VRAM,
// doubles it into a centred 512x384 window and maps it through a 16-entry palette.
module vram_scanout #(
  parameter int H_IMG_START = 64,
  parameter int V_IMG_START = 48
) (
  input logic          render_clk,
  input logic          render_rst_n,
  vram_scanout_if.master bus
);

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_ACT    = 640;
  localparam int V_ACT    = 480;
  localparam int H_SYNC_S = 656;
  localparam int H_SYNC_E = 751;
  localparam int V_SYNC_S = 490;
  localparam int V_SYNC_E = 491;
  localparam int IMG_W    = 512;
  localparam int IMG_H    = 384;

  logic [9:0]  h_p0, v_p0;
  logic [7:0]  x_img, y_img;
  logic        win_p0, nib_p0, vld_p0, hs_p0, vs_p0;
  logic [14:0] addr_p0;

  logic [14:0] addr_p1;
  logic        win_p1, nib_p1, vld_p1, hs_p1, vs_p1;
  logic        win_p2, nib_p2, vld_p2, hs_p2, vs_p2;
  logic [3:0]  idx_p2;
  logic [11:0] rgb_p3;
  logic        hs_p3, vs_p3, vld_p3;

  logic [11:0] pal [16];

  // ---- S0: raster counters and window / nibble decode ----
  always_ff @(posedge render_clk) begin
    if (!render_rst_n) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (h_p0 == 10'(H_TOTAL - 1)) begin
      h_p0 <= '0;
      v_p0 <= (v_p0 == 10'(V_TOTAL - 1)) ? '0 : v_p0 + 10'd1;
    end else begin
      h_p0 <= h_p0 + 10'd1;
    end
  end

  always_comb begin
    x_img   = 8'((h_p0 - 10'(H_IMG_START)) >> 1);
    y_img   = 8'((v_p0 - 10'(V_IMG_START)) >> 1);
    win_p0  = (h_p0 >= 10'(H_IMG_START)) && (h_p0 < 10'(H_IMG_START + IMG_W)) &&
              (v_p0 >= 10'(V_IMG_START)) && (v_p0 < 10'(V_IMG_START + IMG_H));
    vld_p0  = (h_p0 < 10'(H_ACT)) && (v_p0 < 10'(V_ACT));
    hs_p0   = !((h_p0 >= 10'(H_SYNC_S)) && (h_p0 <= 10'(H_SYNC_E)));
    vs_p0   = !((v_p0 >= 10'(V_SYNC_S)) && (v_p0 <= 10'(V_SYNC_E)));
    // Two pixels per byte: byte address drops x_img[0], which picks the nibble.
    addr_p0 = {y_img, x_img[7:1]};
    nib_p0  = x_img[0];
  end

  assign bus.frame_start = (h_p0 == 10'd0) && (v_p0 == 10'(V_ACT));

  // ---- S1: address registered, VRAM read in flight ----
  // ---- S2: VRAM byte arrives, nibble/border select, palette lookup ----
  always_comb begin
    idx_p2 = bus.border_idx;
    if (win_p2) idx_p2 = nib_p2 ? bus.render_data[3:0] : bus.render_data[7:4];
  end

  always_ff @(posedge render_clk) begin
    if (!render_rst_n) begin
      addr_p1 <= '0;
      win_p1  <= 1'b0;
      nib_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b1;
      vs_p1   <= 1'b1;
      win_p2  <= 1'b0;
      nib_p2  <= 1'b0;
      vld_p2  <= 1'b0;
      hs_p2   <= 1'b1;
      vs_p2   <= 1'b1;
      rgb_p3  <= '0;
      vld_p3  <= 1'b0;
      hs_p3   <= 1'b1;
      vs_p3   <= 1'b1;
    end else begin
      // Outside the window the address simply holds; those reads are ignored.
      if (win_p0) addr_p1 <= addr_p0;
      win_p1 <= win_p0;
      nib_p1 <= nib_p0;
      vld_p1 <= vld_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      win_p2 <= win_p1;
      nib_p2 <= nib_p1;
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      rgb_p3 <= vld_p2 ? pal[idx_p2] : '0;
      vld_p3 <= vld_p2;
      hs_p3  <= hs_p2;
      vs_p3  <= vs_p2;
    end
  end

  // Palette reads are combinational, so a same-cycle write is seen next cycle.
  always_ff @(posedge render_clk) begin
    if (!render_rst_n) begin
      for (int i = 0; i < 16; i++) pal[i] <= {3{4'(i)}};
    end else if (bus.pal_we) begin
      pal[bus.pal_addr] <= bus.pal_data;
    end
  end

  // ---- S3: registered video outputs ----
  assign bus.render_addr = addr_p1;
  assign bus.rgb         = rgb_p3;
  assign bus.hsync       = hs_p3;
  assign bus.vsync       = vs_p3;
  assign bus.de          = vld_p3;

endmodule

// File: doc/vram_scanout.md
# vram_scanout

Video scanout stage on the render side of the 24 KiB dual-port VRAM. Generates 640x480@60 VGA timing from a 25.175 MHz pixel clock. Fetches a 256x192, 4 bpp framebuffer through the VRAM render port, scales it 2x into a centred 512x384 window, and maps each 4-bit pixel through a writable 16-entry palette to 12-bit RGB. Everything outside the window is drawn in a selectable border colour.

## Interface
Parameters:
- H_IMG_START, 64: first active column of the image window.
- V_IMG_START, 48: first active line of the image window.

Ports:
- render_clk  in  1  pixel clock; also clocks the VRAM render port.
- render_rst_n  in  1  reset, synchronous, active-low.
- render_addr  out  15  VRAM render-port byte address.
- render_data  in  8  VRAM read data, valid one render_clk after render_addr.
- pal_we  in  1  palette write strobe.
- pal_addr  in  4  palette entry to write.
- pal_data  in  12  {R[3:0],G[3:0],B[3:0]} to write.
- border_idx  in  4  palette index used for border pixels; sampled every cycle.
- rgb  out  12  pixel colour; 0 when de=0.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- de  out  1  640x480 active region.
- frame_start  out  1  one-cycle pulse at start of vertical blanking.

## Operation
- Counters:
  - h: 0..799, wraps to 0. At each h wrap, v advances 0..524 and wraps to 0.
  - Horizontal: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
  - Vertical: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Image window: h in [H_IMG_START, H_IMG_START+511] and v in [V_IMG_START, V_IMG_START+383].
- Image coordinates: x_img = (h-H_IMG_START)>>1 (0..255), y_img = (v-V_IMG_START)>>1 (0..191).
- Address: render_addr = y_img*128 + x_img[7:1]. Range 0..24575 and never exceeds it.
- Nibble order: even x_img takes render_data[7:4]; odd x_img takes render_data[3:0].
- Address updates every cycle inside the window. Outside the window it holds its last value; redundant reads are harmless.
- Pixel index:
  - In window: the selected nibble.
  - In active area outside window: border_idx.
  - Blanking: rgb forced to 0.
- Palette: 16 x 12-bit registers, written when pal_we=1 in any cycle, blanking or not.
  - Reset contents: entry i = {i,i,i} (grey ramp).
  - Simultaneous write and lookup of the same entry: the lookup returns the old value.
- frame_start asserts at the counter stage (not delayed) for h=0, v=480.

## Timing
- Pipeline of 3 registered stages:
  - S0: counters and window/nibble decode; render_addr registered from S0.
  - S1: VRAM read in flight.
  - S2: render_data captured with delayed decode; palette lookup registered into rgb.
- rgb, hsync, vsync and de all correspond to counter state 3 cycles earlier. They stay mutually aligned.
- Reset values while render_rst_n=0 at a clock edge:
  - h=0, v=0, render_addr=0, all pipeline registers cleared.
  - rgb=0, hsync=1, vsync=1, de=0, frame_start=0.
  - Palette restored to the grey ramp.
- First cycle after reset release is counter state (0,0). Its outputs appear 3 cycles later.
- Reset mid-frame: restart from (0,0) with no partial-line artefacts. The delayed sync/de registers are cleared, never left asserted.
- No handshake with VRAM. The render port is read-only and always ready, with fixed 1-cycle latency.

## Test plan
- Reset:
  - Hold render_rst_n=0 for 5 clocks -> rgb=0, hsync=1, vsync=1, de=0, render_addr=0, frame_start=0.
  - After release, de rises exactly 3 clocks later.
- Frame timing:
  - Run 2 frames -> hsync low 96 clocks per 800-clock line; vsync low for 2 lines per 525.
  - frame_start pulses once per 420000 clocks.
- Address sequence on the first image line (v=48):
  - render_addr steps 0,0,0,0,1,1,1,1,…,127 over h=64..575.
  - Line v=50 starts at address 128. Last image pixel reads 24575.
- Pixel mapping, with a VRAM model where byte 0 = 0x3C and palette reset:
  - Output pixels at h=64..67 are 0x333,0x333,0xCCC,0xCCC.
  - Border pixels with border_idx=5 are 0x555; blanking gives rgb=0.
- Palette write:
  - pal_we=1, pal_addr=3, pal_data=0xF00 during active video -> later index-3 pixels read 0xF00.
  - A lookup in the same cycle as the write still returns 0x333.
- Reset mid-frame:
  - Assert reset at v=200, h=300 for 1 clock -> sync/de deassert.
  - Counters restart at (0,0); palette returns to the grey ramp.
